// File: rtl/serial_peri_rx_pkg.sv
// Shared types and default sizing for the serial peripheral receiver.
// The receiver FSM states and the default frame and buffer sizes live here.
package serial_peri_rx_pkg;

   localparam int DEF_FRAME_BITS = 16;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/serial_peri_rx_if.sv
// Received-word stream interface.
// Plain valid/ready handshake carrying one assembled frame per beat.
interface serial_peri_rx_if
   import serial_peri_rx_pkg::*;
#(
   parameter int W = DEF_FRAME_BITS
) ();

   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/serial_peri_rx_sync_fifo.sv
// Single-clock FIFO with registered head word and valid.
// The head register is reloaded every cycle from the post-update read pointer.
module sync_fifo
   import serial_peri_rx_pkg::*;
#(
   parameter int WIDTH = DEF_FRAME_BITS,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      wr_ptr_next;
   logic [AW:0]      rd_ptr_next;
   logic             valid_reg;
   logic [WIDTH-1:0] head_reg;
   logic             pop;
   logic             push;
   logic             bypass;

   assign full = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop  = valid_reg && rd_ready;
   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign push = wr_en && (!full || pop);

   assign wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
   assign rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
   // The slot being written becomes the new head: take it straight from the input.
   assign bypass = push && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         valid_reg  <= 1'b0;
         head_reg   <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         valid_reg  <= (wr_ptr_next != rd_ptr_next);
         head_reg   <= bypass ? wr_data : mem[rd_ptr_next[AW-1:0]];
      end
   end

   assign rd_valid = valid_reg;
   assign rd_data  = head_reg;

endmodule

// File: rtl/serial_peri_rx.sv
// Serial peripheral frame receiver: synchronizes p_clock/p_data/p_cs, assembles
// MSB-first frames of FRAME_BITS bits and queues complete words in a FIFO.
module serial_peri_rx
   import serial_peri_rx_pkg::*;
#(
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_clock,
   input  logic              p_data,
   input  logic              p_cs,
   serial_peri_rx_if.master  out_if,
   output logic              frame_err,
   output logic              overflow,
   output logic              busy
);

   localparam int            CW       = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

   // Bit 1 is chip select (idles high), bit 0 is the serial clock.
   logic [1:0] edge_sync1_reg;
   logic [1:0] edge_sync2_reg;
   logic [1:0] edge_dly_reg;
   logic       data_sync1_reg;
   logic       data_sync2_reg;

   logic sclk_rise;
   logic cs_fall;
   logic cs_rise;

   logic [1:0] settle_reg;
   logic       armed_reg;

   rx_state_t           state_reg;
   rx_state_t           state_next;
   logic [CW-1:0]       count_reg;
   logic [CW-1:0]       count_next;
   logic [FRAME_BITS-1:0] shift_reg;
   logic [FRAME_BITS-1:0] shift_next;
   logic [FRAME_BITS-1:0] shifted;
   logic                wr_en_reg;
   logic                wr_en_next;
   logic                frame_err_reg;
   logic                frame_err_next;
   logic                overflow_reg;
   logic                fifo_full;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         edge_sync1_reg <= 2'b10;
         edge_sync2_reg <= 2'b10;
         edge_dly_reg   <= 2'b10;
         data_sync1_reg <= 1'b0;
         data_sync2_reg <= 1'b0;
      end else begin
         edge_sync1_reg <= {p_cs, p_clock};
         edge_sync2_reg <= edge_sync1_reg;
         edge_dly_reg   <= edge_sync2_reg;
         data_sync1_reg <= p_data;
         data_sync2_reg <= data_sync1_reg;
      end
   end

   assign sclk_rise = edge_sync2_reg[0] && !edge_dly_reg[0];
   assign cs_fall   = !edge_sync2_reg[1] && edge_dly_reg[1];
   assign cs_rise   = edge_sync2_reg[1] && !edge_dly_reg[1];

   // The idle-high reset value of the cs flops fakes a fall when p_cs is already
   // low at release; only arm once the synchronizer holds a genuine high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_reg <= 2'd0;
         armed_reg  <= 1'b0;
      end else begin
         if (settle_reg != 2'd2) begin
            settle_reg <= settle_reg + 2'd1;
         end
         if (settle_reg == 2'd2 && edge_sync2_reg[1]) begin
            armed_reg <= 1'b1;
         end
      end
   end

   assign shifted = {shift_reg[FRAME_BITS-2:0], data_sync2_reg};

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      shift_next     = shift_reg;
      wr_en_next     = 1'b0;
      frame_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (armed_reg && cs_fall) begin
               state_next = SHIFT;
               count_next = '0;
               shift_next = '0;
            end
         end
         SHIFT: begin
            if (sclk_rise && count_reg == LAST_CNT) begin
               shift_next = shifted;
               count_next = count_reg + 1'b1;
               wr_en_next = 1'b1;
               state_next = cs_rise ? IDLE : DONE;
            end else if (cs_rise) begin
               state_next     = IDLE;
               frame_err_next = (count_reg != '0);
            end else if (sclk_rise) begin
               shift_next = shifted;
               count_next = count_reg + 1'b1;
            end
         end
         DONE: begin
            if (cs_rise) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         shift_reg     <= '0;
         wr_en_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         shift_reg     <= shift_next;
         wr_en_reg     <= wr_en_next;
         frame_err_reg <= frame_err_next;
         overflow_reg  <= wr_en_reg && fifo_full && !(out_if.out_valid && out_if.out_ready);
      end
   end

   // shift_reg still holds the completed word in the write cycle.
   sync_fifo #(
      .WIDTH (FRAME_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en_reg),
      .wr_data  (shift_reg),
      .full     (fifo_full),
      .rd_valid (out_if.out_valid),
      .rd_ready (out_if.out_ready),
      .rd_data  (out_if.out_data)
   );

   assign frame_err = frame_err_reg;
   assign overflow  = overflow_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_peri_rx.sv
// Directed bench for serial_peri_rx: frames, fill/overflow, short and long
// frames, reset behaviour and write-during-pop on a full buffer.
module tb_serial_peri_rx;

   logic clock   = 1'b0;
   logic reset   = 1'b0;
   logic p_clock = 1'b0;
   logic p_data  = 1'b0;
   logic p_cs    = 1'b0;
   logic frame_err;
   logic overflow;
   logic busy;

   serial_peri_rx_if #(.W(16)) rx_if ();

   serial_peri_rx #(
      .FRAME_BITS (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .p_clock   (p_clock),
      .p_data    (p_data),
      .p_cs      (p_cs),
      .out_if    (rx_if.master),
      .frame_err (frame_err),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [15:0] beat_q[$];
   int err_cycles = 0;
   int ovf_cycles = 0;

   always @(negedge clock) begin
      if (rx_if.out_valid && rx_if.out_ready) begin
         beat_q.push_back(rx_if.out_data);
         $display("beat %0d data=%h", beat_q.size(), rx_if.out_data);
      end
      if (frame_err) err_cycles++;
      if (overflow) ovf_cycles++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not finish, want finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      p_data = b;
      wait_clk(4);
      p_clock = 1'b1;
      wait_clk(4);
      p_clock = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] v, input int n);
      p_cs = 1'b0;
      wait_clk(4);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
      wait_clk(4);
      p_cs = 1'b1;
      wait_clk(6);
   endtask

   task automatic test_reset();
      int base;
      p_cs = 1'b0;
      reset = 1'b0;
      rx_if.out_ready = 1'b1;
      wait_clk(3);
      total++; if (rx_if.out_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", rx_if.out_data); end
      total++; if (rx_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rx_if.out_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      // Release with p_cs low: clocking a frame in must not start reception.
      base = beat_q.size();
      reset = 1'b1;
      wait_clk(6);
      for (int i = 0; i < 16; i++) send_bit(1'b1);
      wait_clk(6);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL cs_low_busy: got %b want 0", busy); end
      total++; if (beat_q.size() - base !== 0) begin bad++; $display("FAIL cs_low_beats: got %0d want 0", beat_q.size() - base); end
      p_cs = 1'b1;
      wait_clk(6);
   endtask

   task automatic test_single();
      int base, ebase, obase;
      logic [15:0] v;
      v = 16'hA5C3;
      base = beat_q.size(); ebase = err_cycles; obase = ovf_cycles;
      rx_if.out_ready = 1'b0;
      p_cs = 1'b0;
      wait_clk(4);
      for (int i = 15; i >= 1; i--) send_bit(v[i]);
      p_data = v[0];
      wait_clk(4);
      p_clock = 1'b1;
      wait_clk(3);
      total++; if (rx_if.out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got valid=%b want 0", rx_if.out_valid); end
      wait_clk(1);
      total++; if (rx_if.out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want 1", rx_if.out_valid); end
      total++; if (rx_if.out_data !== 16'hA5C3) begin bad++; $display("FAIL lat_data: got %h want a5c3", rx_if.out_data); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL done_busy: got %b want 1", busy); end
      wait_clk(3);
      p_clock = 1'b0;
      wait_clk(4);
      p_cs = 1'b1;
      wait_clk(6);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
      rx_if.out_ready = 1'b1;
      wait_clk(4);
      total++; if (beat_q.size() - base !== 1) begin bad++; $display("FAIL single_beats: got %0d want 1", beat_q.size() - base); end
      else begin
         total++; if (beat_q[base] !== 16'hA5C3) begin bad++; $display("FAIL single_data: got %h want a5c3", beat_q[base]); end
      end
      total++; if (err_cycles - ebase !== 0) begin bad++; $display("FAIL single_ferr: got %0d want 0", err_cycles - ebase); end
      total++; if (ovf_cycles - obase !== 0) begin bad++; $display("FAIL single_ovf: got %0d want 0", ovf_cycles - obase); end
   endtask

   task automatic test_fill();
      int base, ebase, obase;
      logic [15:0] exp_v;
      base = beat_q.size(); ebase = err_cycles; obase = ovf_cycles;
      rx_if.out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send_frame(32'(k), 16);
      total++; if (ovf_cycles - obase !== 1) begin bad++; $display("FAIL fill_ovf: got %0d pulse cycles want 1", ovf_cycles - obase); end
      total++; if (err_cycles - ebase !== 0) begin bad++; $display("FAIL fill_ferr: got %0d want 0", err_cycles - ebase); end
      total++; if (rx_if.out_data !== 16'h0001) begin bad++; $display("FAIL fill_head: got %h want 0001", rx_if.out_data); end
      rx_if.out_ready = 1'b1;
      wait_clk(8);
      rx_if.out_ready = 1'b0;
      total++; if (beat_q.size() - base !== 4) begin bad++; $display("FAIL fill_beats: got %0d want 4", beat_q.size() - base); end
      else begin
         for (int i = 0; i < 4; i++) begin
            exp_v = 16'(i + 1);
            total++; if (beat_q[base + i] !== exp_v) begin bad++; $display("FAIL fill_order%0d: got %h want %h", i, beat_q[base + i], exp_v); end
         end
      end
      total++; if (rx_if.out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty: got %b want 0", rx_if.out_valid); end
   endtask

   task automatic test_short();
      int base, ebase;
      base = beat_q.size(); ebase = err_cycles;
      rx_if.out_ready = 1'b1;
      send_frame(32'h55, 7);
      total++; if (err_cycles - ebase !== 1) begin bad++; $display("FAIL short_ferr: got %0d pulse cycles want 1", err_cycles - ebase); end
      total++; if (beat_q.size() - base !== 0) begin bad++; $display("FAIL short_beats: got %0d want 0", beat_q.size() - base); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL short_busy: got %b want 0", busy); end
      send_frame(32'h1234, 16);
      wait_clk(4);
      total++; if (beat_q.size() - base !== 1) begin bad++; $display("FAIL after_short_beats: got %0d want 1", beat_q.size() - base); end
      else begin
         total++; if (beat_q[base] !== 16'h1234) begin bad++; $display("FAIL after_short_data: got %h want 1234", beat_q[base]); end
      end
      total++; if (err_cycles - ebase !== 1) begin bad++; $display("FAIL after_short_ferr: got %0d want 1", err_cycles - ebase); end
   endtask

   task automatic test_long();
      int base, ebase;
      base = beat_q.size(); ebase = err_cycles;
      rx_if.out_ready = 1'b1;
      send_frame(32'hBEEFF, 20);
      wait_clk(4);
      total++; if (beat_q.size() - base !== 1) begin bad++; $display("FAIL long_beats: got %0d want 1", beat_q.size() - base); end
      else begin
         total++; if (beat_q[base] !== 16'hBEEF) begin bad++; $display("FAIL long_data: got %h want beef", beat_q[base]); end
      end
      total++; if (err_cycles - ebase !== 0) begin bad++; $display("FAIL long_ferr: got %0d want 0", err_cycles - ebase); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL long_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int base, ebase;
      logic [15:0] v;
      v = 16'h5A5A;
      rx_if.out_ready = 1'b0;
      send_frame(32'h0F0F, 16);
      total++; if (rx_if.out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid: got %b want 1", rx_if.out_valid); end
      ebase = err_cycles;
      p_cs = 1'b0;
      wait_clk(4);
      for (int i = 15; i >= 7; i--) send_bit(v[i]);
      reset = 1'b0;
      wait_clk(2);
      total++; if (rx_if.out_data !== 16'h0000) begin bad++; $display("FAIL mid_rst_data: got %h want 0000", rx_if.out_data); end
      total++; if (rx_if.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", rx_if.out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
      p_cs = 1'b1;
      wait_clk(2);
      reset = 1'b1;
      wait_clk(6);
      base = beat_q.size();
      rx_if.out_ready = 1'b1;
      send_frame(32'h5A5A, 16);
      wait_clk(4);
      total++; if (beat_q.size() - base !== 1) begin bad++; $display("FAIL post_rst_beats: got %0d want 1", beat_q.size() - base); end
      else begin
         total++; if (beat_q[base] !== 16'h5A5A) begin bad++; $display("FAIL post_rst_data: got %h want 5a5a", beat_q[base]); end
      end
      total++; if (err_cycles - ebase !== 0) begin bad++; $display("FAIL mid_rst_ferr: got %0d want 0", err_cycles - ebase); end
   endtask

   task automatic test_back_to_back();
      int base, obase;
      logic [15:0] v;
      logic [15:0] exp_v;
      base = beat_q.size(); obase = ovf_cycles;
      rx_if.out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send_frame(32'(k * 17), 16);
      total++; if (ovf_cycles - obase !== 0) begin bad++; $display("FAIL b2b_fill_ovf: got %0d want 0", ovf_cycles - obase); end
      v = 16'h0055;
      p_cs = 1'b0;
      wait_clk(4);
      for (int i = 15; i >= 1; i--) send_bit(v[i]);
      p_data = v[0];
      wait_clk(4);
      p_clock = 1'b1;
      wait_clk(3);
      // Pop exactly in the cycle the completed word is written.
      rx_if.out_ready = 1'b1;
      wait_clk(1);
      rx_if.out_ready = 1'b0;
      wait_clk(3);
      p_clock = 1'b0;
      wait_clk(4);
      p_cs = 1'b1;
      wait_clk(6);
      total++; if (ovf_cycles - obase !== 0) begin bad++; $display("FAIL b2b_ovf: got %0d want 0", ovf_cycles - obase); end
      total++; if (rx_if.out_data !== 16'h0022) begin bad++; $display("FAIL b2b_head: got %h want 0022", rx_if.out_data); end
      rx_if.out_ready = 1'b1;
      wait_clk(8);
      rx_if.out_ready = 1'b0;
      total++; if (beat_q.size() - base !== 5) begin bad++; $display("FAIL b2b_beats: got %0d want 5", beat_q.size() - base); end
      else begin
         for (int i = 0; i < 5; i++) begin
            exp_v = 16'((i + 1) * 17);
            total++; if (beat_q[base + i] !== exp_v) begin bad++; $display("FAIL b2b_order%0d: got %h want %h", i, beat_q[base + i], exp_v); end
         end
      end
      total++; if (rx_if.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", rx_if.out_valid); end
   endtask

   initial begin
      rx_if.out_ready = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_short();
      test_long();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_peri_rx.md
SERIAL_PERI_RX -- requirements
Module: serial_peri_rx

Interface
REQ-001 Parameter: FRAME_BITS, 16, bits per serial frame (range 2..32).
REQ-002 Parameter: FIFO_DEPTH, 4, received-word buffer depth (power of two, at least 2).
REQ-003 Port: clock  input  1  the single system clock; all logic is in this domain.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: p_clock  input  1  serial clock from the peripheral master; asynchronous to clock.
REQ-006 Port: p_data  input  1  serial data, MSB first; asynchronous.
REQ-007 Port: p_cs  input  1  chip select, active-low; asynchronous.
REQ-008 Port: out_data  output  FRAME_BITS  head-of-buffer word.
REQ-009 Port: out_valid  output  1  buffer not empty.
REQ-010 Port: out_ready  input  1  consumer accepts the word; a pop occurs when out_valid and out_ready are both high.
REQ-011 Port: frame_err  output  1  one-cycle pulse when a short frame is discarded.
REQ-012 Port: overflow  output  1  one-cycle pulse when a complete frame is dropped because the buffer is full.
REQ-013 Port: busy  output  1  high while the receiver is in SHIFT or DONE.

Function
REQ-014 p_clock, p_data and p_cs SHALL each pass through a 2-flop synchronizer.
REQ-015 Edge detection SHALL use a third registered copy of each synchronized signal.
REQ-016 A rising p_clock edge SHALL be detected in the cycle where the synchronized value is 1 and the delayed value is 0 (cycle E).
REQ-017 The synchronized p_data SHALL be sampled in cycle E.
REQ-018 Inputs are guaranteed stable: p_clock high and low phases are each at least 3 clock periods, and p_data is stable at least 3 clock periods around each rising p_clock edge.
REQ-019 FSM SHALL have states IDLE, SHIFT and DONE.
REQ-020 IDLE -> SHIFT on a falling edge of synchronized p_cs; the bit counter and shift register SHALL clear on this transition.
REQ-021 In SHIFT, each rising edge SHALL shift the sampled bit into the LSB (MSB first) and increment the counter.
REQ-022 In SHIFT, on the edge that makes the count equal FRAME_BITS, the assembled word SHALL be written to the buffer in cycle E+1 and the FSM SHALL go to DONE.
REQ-023 In DONE, further p_clock edges SHALL be ignored, and a rise of p_cs SHALL return the FSM to IDLE with no error.
REQ-024 In SHIFT, a p_cs rise SHALL return the FSM to IDLE and discard the partial word.
REQ-025 For the short frame in REQ-024, frame_err SHALL pulse once if the count was between 1 and FRAME_BITS-1; a count of 0 SHALL produce no pulse.
REQ-026 In SHIFT, a p_cs rise in the same cycle as the completing edge SHALL complete the frame (write the word), then go to IDLE; frame_err SHALL stay low.
REQ-027 The buffer is a FIFO: out_data/out_valid SHALL be registered.
REQ-028 A word written to an empty FIFO SHALL appear on out_data/out_valid in cycle E+2.
REQ-029 A write to a full FIFO SHALL drop the word and pulse overflow.
REQ-030 Exception to REQ-029: if a pop occurs in the same cycle as a write to a full FIFO, the write SHALL be accepted and overflow SHALL stay low.
REQ-031 A simultaneous write and pop on a non-full FIFO SHALL leave the occupancy unchanged.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH, using one extra bit to distinguish full from empty.

Reset
REQ-033 While reset is low, the FSM SHALL be in IDLE and the counter, shift register and FIFO pointers SHALL be 0.
REQ-034 While reset is low, the p_cs synchronizer and delay flops SHALL be 1 (idle-high); the p_clock and p_data flops SHALL be 0.
REQ-035 While reset is low, out_data SHALL be 0 and out_valid, frame_err, overflow and busy SHALL be 0.
REQ-036 After reset releases with p_cs already low, no frame SHALL start until p_cs goes high and then falls again.
REQ-037 Reset mid-frame SHALL discard the partial word and the FIFO contents without pulsing frame_err.

Structure
REQ-038 A shared package SHALL hold the FSM state enum (IDLE, SHIFT, DONE) and the default values of FRAME_BITS and FIFO_DEPTH.
REQ-039 The FIFO SHALL be a separate sub-module, sync_fifo, parameterized by width and depth, with write/full and valid/ready/data ports.
REQ-040 Synchronizers, edge detection, the FSM and the shift register SHALL reside in serial_peri_rx.

Verification
REQ-041 Single frame: p_cs low, 16 edges of 0xA5C3, p_cs high, out_ready=1 -> one beat with out_data=0xA5C3; frame_err=0, overflow=0.
REQ-042 Fill: out_ready=0, five frames 0x0001..0x0005 -> 4 words buffered; overflow pulses once on the fifth; then out_ready=1 drains 0x0001..0x0004 in order.
REQ-043 Short frame: 7 edges, then p_cs high -> frame_err single pulse, out_valid stays 0, busy returns to 0; a following full frame 0x1234 is received correctly.
REQ-044 Long frame: 20 edges of 0xBEEF followed by 0xF -> out_data=0xBEEF exactly once; no frame_err.
REQ-045 Reset after 9 bits of a frame -> all outputs 0; the next full frame 0x5A5A is received correctly.
REQ-046 FIFO full with out_ready=1 and a frame completing in the pop cycle -> no overflow; occupancy stays 4; the order is preserved.
